// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor, one CW-bit chunk per stage.
// Ports: clk, rst, in_valid/in_ready, a, b, cin, sub -> out_valid/out_ready, sum, cout, ovf.
module pipelined_rca_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g
    logic [WIDTH-1:0] xa, xb, xs, ns;
    logic             xc, xv;
    logic [WIDTH-1:0] ra, rb, rs;
    logic             rc, rv;
    logic [CW:0]      t;

    if (k == 0) begin : head
      assign xa = a;
      assign xb = b ^ {WIDTH{sub}};
      assign xs = '0;
      assign xc = sub | cin;
      assign xv = in_valid;
    end else begin : body
      assign xa = g[k-1].ra;
      assign xb = g[k-1].rb;
      assign xs = g[k-1].rs;
      assign xc = g[k-1].rc;
      assign xv = g[k-1].rv;
    end

    assign t = {1'b0, xa[k*CW +: CW]}
             + {1'b0, xb[k*CW +: CW]}
             + {{CW{1'b0}}, xc};

    always_comb begin
      ns = xs;
      ns[k*CW +: CW] = t[CW-1:0];
    end

    // Data registers load only with a live beat, so the
    // output holds its last result across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        rv <= 1'b0;
        ra <= '0;
        rb <= '0;
        rs <= '0;
        rc <= 1'b0;
      end else if (adv) begin
        rv <= xv;
        if (xv) begin
          ra <= xa;
          rb <= xb;
          rs <= ns;
          rc <= t[CW];
        end
      end
    end
  end

  assign out_valid = g[STAGES-1].rv;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign sum       = g[STAGES-1].rs;
  assign cout      = g[STAGES-1].rc;

  // Carry into the MSB is recovered as a^b'^s at that bit.
  assign ovf = g[STAGES-1].ra[WIDTH-1]
             ^ g[STAGES-1].rb[WIDTH-1]
             ^ g[STAGES-1].rs[WIDTH-1]
             ^ g[STAGES-1].rc;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Scoreboard bench for pipelined_rca_addsub (32/4 instance plus an 8/1 instance).
// Issue side pushes expected {ovf,cout,sum}; a negedge monitor pops and compares.
module tb_pipelined_rca_addsub;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub;
  logic [31:0] a, b, sum;
  logic        out_valid, out_ready, cout, ovf;

  logic       in_valid8, in_ready8, out_valid8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [33:0] sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_rca_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_rca_addsub #(.WIDTH(8), .STAGES(1)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid8), .out_ready(1'b1),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] x, y,
                                        input logic c, s);
    logic [31:0] yb;
    logic [32:0] r;
    logic        v;
    yb = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yb} + {32'd0, (s ? 1'b1 : c)};
    v  = (x[31] == yb[31]) && (r[31] != x[31]);
    return {v, r[32], r[31:0]};
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_result got=%h exp=none",
                 {ovf, cout, sum});
      end else begin
        e = sbq.pop_front();
        chk("result", {30'd0, ovf, cout, sum}, {30'd0, e});
      end
    end
  end

  task automatic send(input logic [31:0] ia, ib, input logic ic, is,
                      input logic [33:0] e);
    int n = 0;
    in_valid = 1'b1;
    a = ia; b = ib; cin = ic; sub = is;
    @(negedge clk);
    while (!in_ready && n < TMO) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout got=in_ready0 exp=in_ready1");
    end else begin
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < TMO) begin
      n++;
      @(posedge clk);
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int seen;
    logic [31:0] hold;
    logic [31:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'({ovf, cout, sum}), 64'd0);
    chk("rst8", 64'({out_valid8, ovf8, cout8, sum8, in_ready8}), 64'd1);

    // 8-bit, single stage: latency 1
    @(posedge clk);
    #1 in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_valid", 64'(out_valid8), 64'd1);
    chk("w8_res", 64'({ovf8, cout8, sum8}), 64'({1'b0, 1'b1, 8'h00}));
    @(negedge clk);
    chk("w8_bubble", 64'({out_valid8, sum8}), 64'({1'b0, 8'h00}));

    // Directed vectors, hand-computed {ovf,cout,sum}
    @(posedge clk);
    #1;
    t0 = cyc;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {2'b10, 32'h8000_0000});
    chk("lat_first_empty", 64'(out_valid), 64'd0);
    send(32'h5, 32'h7, 1'b1, 1'b1, {2'b00, 32'hFFFF_FFFE});
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {2'b01, 32'h0});
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, {2'b11, 32'h7FFF_FFFF});
    send(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, {2'b00, 32'h0001_FFFF});
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, {2'b01, 32'h0});
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {2'b11, 32'h0});
    send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, {2'b00, 32'h0100_0100});
    drain();

    // 100 back-to-back random beats
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    chk("throughput_cycles", 64'(cyc - t0), 64'd100);
    drain();

    // Backpressure with full pipe
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          ra = 32'h1111_1111 * 32'(i + 1);
          rb = 32'h0F0F_0F0F;
          send(ra, rb, 1'b1, i[0], model(ra, rb, 1'b1, i[0]));
        end
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < TMO) begin
          n++;
          @(negedge clk);
        end
        chk("bp_fill", 64'(out_valid), 64'd1);
        hold = sum;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_stable", 64'({out_valid, sum}), 64'({1'b1, hold}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      ra = 32'hA5A5_0000 + 32'(i);
      send(ra, 32'h1, 1'b0, 1'b0, model(ra, 32'h1, 1'b0, 1'b0));
    end
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_stale", 64'(seen), 64'd0);

    // Pipe still usable after reset
    @(posedge clk);
    #1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, {2'b01, 32'hFFFF_FFFF});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
